decoder_3to8_seq: RTL and testbench
===================================

Name: decoder_3to8_seq

Overview:
- Sequenced 3-to-8 decoder. It is the receive-side counterpart of the team's 8:3 encoder.
- Accepts 3-bit binary codes over a valid/ready handshake and buffers them in a small FIFO.
- Drives each code out as a registered one-hot 8-bit word, held for a programmable number of cycles.
- Sits between a code source (encoder, controller) and downstream line-select logic.

Parameters:
- HOLD, 4: cycles each one-hot word stays on y; legal range 1..255.
- FIFO_DEPTH, 4: code buffer entries; power of two, at least 2.

Ports:
- clk  input  1  single rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_code is valid this cycle.
- in_ready  output  1  FIFO can accept a code; equals !full.
- in_code  input  3  binary code 0..7.
- en  input  1  allows new codes to be popped and decoded.
- flush  input  1  synchronous clear of FIFO and output.
- y  output  8  one-hot decoded word; y[k]=1 for code k.
- y_valid  output  1  y holds a decoded word.
- busy  output  1  FIFO not empty or state is HOLD.
- dec_cnt  output  8  count of decoded codes, wraps.

Behaviour:
- Reset (rst_n=0, asynchronous, any time, including mid-hold):
  - FIFO empty, state IDLE, hold counter 0.
  - y=8'h00, y_valid=0, dec_cnt=0, busy=0.
  - in_ready=1 once rst_n is released.
- Push:
  - A code is accepted on a rising edge when in_valid && in_ready && !flush.
  - There is no push when full. in_valid while full is simply stalled; nothing is lost.
- FSM, states IDLE and HOLD:
  - IDLE: if FIFO not empty and en=1, pop the head at the edge. Then set y<=1<<code, y_valid<=1, counter<=HOLD-1, dec_cnt<=dec_cnt+1, and go to HOLD. Otherwise y=0 and y_valid=0.
  - HOLD, counter>0: decrement; y is held unchanged.
  - HOLD, counter==0: if FIFO not empty and en=1, pop the next code back-to-back with no gap. This loads the new y, reloads the counter to HOLD-1 and increments dec_cnt. Otherwise y<=0, y_valid<=0, go to IDLE.
- Hold length:
  - Each word is on y for exactly HOLD cycles.
  - HOLD=1 gives one new word per cycle with continuous y_valid.
- Latency:
  - A code pushed at edge k into an empty FIFO in IDLE with en=1 is popped at edge k+1. y is valid after edge k+1.
  - There is no fall-through: pop decisions use the pre-edge FIFO count.
- Simultaneous push and pop: both occur on the same edge and the occupancy is unchanged.
- Ordering: FIFO order is strictly preserved.
- en=0:
  - A word already in HOLD finishes its full HOLD cycles.
  - No new pop happens while en=0. Pushes still proceed.
- flush=1 (synchronous, highest priority after reset):
  - At the edge, the FIFO is emptied, state goes to IDLE, y=0, y_valid=0, and the counter is cleared.
  - dec_cnt is unchanged.
  - Any push in the same cycle is discarded.
- dec_cnt: 8-bit and wraps 255 -> 0.
- busy: combinational, (count!=0) || (state==HOLD).
- Invariant: y is always 8'h00 or exactly one bit set. y_valid==|y.

Test Plan:
- Reset, then push code 3 with HOLD=4 -> y=8'h08 after 1 cycle, held exactly 4 cycles, then y=0 and y_valid=0; dec_cnt=1.
- Push codes 0..7 in a burst with HOLD=1 -> in_ready drops once 4 entries are held. y steps 01,02,04,...,80 on consecutive cycles with y_valid continuously 1. dec_cnt=8.
- en=0, push 5,6,1 -> FIFO full after 3 pushes plus 1 more (4 entries), y=0, busy=1. Set en=1 -> y shows 20,40,02 in order.
- Assert flush while holding y=8'h10 with 2 codes queued -> next cycle y=0, y_valid=0, busy=0, in_ready=1; dec_cnt is unchanged.
- Drop rst_n asynchronously in the middle of a HOLD -> outputs clear immediately without a clock edge. After release, a push of 7 gives y=8'h80.
- Decode 256 codes -> dec_cnt wraps to 0; the one-hot invariant is asserted every cycle.

Source files
------------

// File: rtl/decoder_3to8_seq.sv
// Sequenced 3-to-8 decoder: codes arrive over valid/ready into a small FIFO and
// are driven out as registered one-hot words, each held for HOLD cycles.
module decoder_3to8_seq #(
  parameter int HOLD       = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_code,
  input  logic       en,
  input  logic       flush,
  output logic [7:0] y,
  output logic       y_valid,
  output logic       busy,
  output logic [7:0] dec_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  logic [2:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  state_t        state_q, state_d;
  logic [7:0]    hold_q, hold_d;
  logic [7:0]    y_q, y_d;
  logic [7:0]    dec_cnt_q, dec_cnt_d;
  logic          full, empty, push, pop, can_pop;
  logic [2:0]    head;

  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign push    = in_valid && !full && !flush;
  assign can_pop = !empty && en;
  assign head    = mem_q[rd_ptr_q];

  // Code storage carries no reset; occupancy is tracked by the pointers/count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_code;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      hold_q    <= '0;
      y_q       <= '0;
      dec_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      y_q       <= y_d;
      dec_cnt_q <= dec_cnt_d;
    end
  end

  // Next-state: a pop decision looks only at the pre-edge count (no fall-through).
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    y_d       = y_q;
    dec_cnt_d = dec_cnt_q;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (can_pop) begin
          pop       = 1'b1;
          state_d   = S_HOLD;
          hold_d    = 8'(HOLD - 1);
          y_d       = 8'b1 << head;
          dec_cnt_d = dec_cnt_q + 8'd1;
        end else begin
          y_d = '0;
        end
      end
      S_HOLD: begin
        if (hold_q != '0) begin
          hold_d = hold_q - 8'd1;
        end else if (can_pop) begin
          pop       = 1'b1;
          hold_d    = 8'(HOLD - 1);
          y_d       = 8'b1 << head;
          dec_cnt_d = dec_cnt_q + 8'd1;
        end else begin
          y_d     = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      pop       = 1'b0;
      state_d   = S_IDLE;
      hold_d    = '0;
      y_d       = '0;
      dec_cnt_d = dec_cnt_q;
    end
  end

  // Outputs
  always_comb begin
    y        = y_q;
    y_valid  = |y_q;
    busy     = !empty || (state_q == S_HOLD);
    in_ready = !full;
    dec_cnt  = dec_cnt_q;
  end

endmodule

// File: tb/tb_decoder_3to8_seq.sv
// Directed bench for decoder_3to8_seq: one instance with HOLD=4, one with HOLD=1.
module tb_decoder_3to8_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       iv4, en4, fl4, rdy4, yv4, bsy4;
  logic [2:0] ic4;
  logic [7:0] y4, dc4;
  logic       iv1, en1, fl1, rdy1, yv1, bsy1;
  logic [2:0] ic1;
  logic [7:0] y1, dc1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  decoder_3to8_seq #(.HOLD(4), .FIFO_DEPTH(4)) u_h4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(rdy4), .in_code(ic4),
    .en(en4), .flush(fl4), .y(y4), .y_valid(yv4), .busy(bsy4), .dec_cnt(dc4)
  );

  decoder_3to8_seq #(.HOLD(1), .FIFO_DEPTH(4)) u_h1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(rdy1), .in_code(ic1),
    .en(en1), .flush(fl1), .y(y1), .y_valid(yv1), .busy(bsy1), .dec_cnt(dc1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One-hot invariant on both instances every cycle.
  always @(negedge clk) begin
    chk("onehot4", 32'((y4 == 8'h00) || $onehot(y4)), 32'd1);
    chk("yvalid4", 32'(yv4), 32'(y4 != 8'h00));
    chk("onehot1", 32'((y1 == 8'h00) || $onehot(y1)), 32'd1);
    chk("yvalid1", 32'(yv1), 32'(y1 != 8'h00));
  end

  logic [7:0] exp3 [4];
  int nxt;

  initial begin
    rst_n = 1'b0;
    iv4 = 0; ic4 = 0; en4 = 1; fl4 = 0;
    iv1 = 0; ic1 = 0; en1 = 0; fl1 = 0;
    #1;
    chk("rst_y", 32'(y4), 32'h00);
    chk("rst_yv", 32'(yv4), 32'd0);
    chk("rst_dc", 32'(dc4), 32'd0);
    chk("rst_busy", 32'(bsy4), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rdy_after_rst", 32'(rdy4), 32'd1);

    // Single code 3 held for 4 cycles
    iv4 = 1; ic4 = 3;
    @(negedge clk);
    iv4 = 0;
    chk("t1_lat_y", 32'(y4), 32'h00);
    chk("t1_busy", 32'(bsy4), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t1_y", 32'(y4), 32'h08);
      chk("t1_yv", 32'(yv4), 32'd1);
    end
    @(negedge clk);
    chk("t1_end_y", 32'(y4), 32'h00);
    chk("t1_end_yv", 32'(yv4), 32'd0);
    chk("t1_dc", 32'(dc4), 32'd1);
    chk("t1_idle_busy", 32'(bsy4), 32'd0);

    // HOLD=1 burst 0..7: fill with en=0, then stream back-to-back
    for (int i = 0; i < 4; i++) begin
      iv1 = 1; ic1 = 3'(i);
      @(negedge clk);
    end
    chk("t2_full_rdy", 32'(rdy1), 32'd0);
    chk("t2_full_y", 32'(y1), 32'h00);
    chk("t2_full_busy", 32'(bsy1), 32'd1);
    nxt = 4; ic1 = 3'(nxt); en1 = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t2_y", 32'(y1), 32'(8'h01 << i));
      chk("t2_yv", 32'(yv1), 32'd1);
      if (i >= 1) nxt++;
      iv1 = (nxt < 8);
      ic1 = 3'(nxt);
    end
    @(negedge clk);
    chk("t2_end_y", 32'(y1), 32'h00);
    chk("t2_dc", 32'(dc1), 32'd8);

    // en=0 fill with 5,6,1,2 then release
    en4 = 0;
    exp3[0] = 8'h20; exp3[1] = 8'h40; exp3[2] = 8'h02; exp3[3] = 8'h04;
    iv4 = 1; ic4 = 5; @(negedge clk);
    ic4 = 6; @(negedge clk);
    ic4 = 1; @(negedge clk);
    chk("t3_rdy3", 32'(rdy4), 32'd1);
    ic4 = 2; @(negedge clk);
    iv4 = 0;
    chk("t3_full_rdy", 32'(rdy4), 32'd0);
    chk("t3_y", 32'(y4), 32'h00);
    chk("t3_busy", 32'(bsy4), 32'd1);
    en4 = 1;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      chk("t3_seq", 32'(y4), 32'(exp3[j >> 2]));
    end
    @(negedge clk);
    chk("t3_end_y", 32'(y4), 32'h00);
    chk("t3_dc", 32'(dc4), 32'd5);

    // Flush while holding 8'h10 with two codes queued
    iv4 = 1; ic4 = 4; @(negedge clk);
    ic4 = 1; @(negedge clk);
    ic4 = 2; @(negedge clk);
    chk("t4_pre_y", 32'(y4), 32'h10);
    fl4 = 1; iv4 = 1; ic4 = 7;
    @(negedge clk);
    fl4 = 0; iv4 = 0;
    chk("t4_y", 32'(y4), 32'h00);
    chk("t4_yv", 32'(yv4), 32'd0);
    chk("t4_busy", 32'(bsy4), 32'd0);
    chk("t4_rdy", 32'(rdy4), 32'd1);
    chk("t4_dc", 32'(dc4), 32'd6);
    @(negedge clk);
    chk("t4_discard_busy", 32'(bsy4), 32'd0);
    chk("t4_discard_y", 32'(y4), 32'h00);

    // Asynchronous reset in the middle of a hold
    iv4 = 1; ic4 = 6; @(negedge clk);
    iv4 = 0; @(negedge clk);
    chk("t5_pre_y", 32'(y4), 32'h40);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_y", 32'(y4), 32'h00);
    chk("t5_rst_yv", 32'(yv4), 32'd0);
    chk("t5_rst_busy", 32'(bsy4), 32'd0);
    chk("t5_rst_dc", 32'(dc4), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    iv4 = 1; ic4 = 7; @(negedge clk);
    iv4 = 0; @(negedge clk);
    chk("t5_y", 32'(y4), 32'h80);
    chk("t5_dc", 32'(dc4), 32'd1);

    // 256 decodes on the HOLD=1 instance: dec_cnt wraps
    en1 = 1;
    for (int i = 0; i < 256; i++) begin
      if (i >= 2) chk("t6_y", 32'(y1), 32'(8'h01 << ((i - 2) & 7)));
      iv1 = 1; ic1 = 3'(i & 7);
      @(negedge clk);
    end
    iv1 = 0;
    chk("t6_dc255", 32'(dc1), 32'd255);
    @(negedge clk);
    chk("t6_last_y", 32'(y1), 32'h80);
    chk("t6_wrap", 32'(dc1), 32'd0);
    @(negedge clk);
    chk("t6_idle_y", 32'(y1), 32'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
